// File: rtl/operand_fetch.sv
// operand_fetch: computes the effective address for a decoded 6502-style
// instruction, performs pointer and operand reads through a single-outstanding
// read port, and hands opcode, EA and operand byte to execute.
//
// Ports:
//   clk_i, rst_i             clock, asynchronous active-high reset
//   valid_i / ready_o        upstream handshake (decoded instruction)
//   opcode_i, addr_mode_i    opcode byte and addressing mode (13-15 act as IMP)
//   load_i                   instruction reads the byte at EA
//   operand_i                operand bytes, [7:0] first, [15:8] second
//   pc_i                     address of next instruction (REL base)
//   X_i, Y_i                 index registers, sampled at accept
//   mem_req_o, mem_addr_o    read request and address (held while pending)
//   mem_rvalid_i, mem_rdata_i read response
//   valid_o / ready_i        downstream handshake (result)
//   opcode_o, ea_o, operand_o, page_cross_o   result payload
//
// Build option: define NMOS_JMP_IND_BUG_EN to fetch the IND high pointer byte
// from {op[15:8], op[7:0]+1} (page wrap) instead of op+1.
module operand_fetch #(
    parameter int unsigned MEM_ADDR_SIZE = 16,
    parameter int unsigned REG_SIZE      = 8,
    parameter int unsigned BYTE          = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     valid_i,
    output logic                     ready_o,
    input  logic [BYTE-1:0]          opcode_i,
    input  logic [3:0]               addr_mode_i,
    input  logic                     load_i,
    input  logic [2*BYTE-1:0]        operand_i,
    input  logic [MEM_ADDR_SIZE-1:0] pc_i,
    input  logic [REG_SIZE-1:0]      X_i,
    input  logic [REG_SIZE-1:0]      Y_i,
    output logic                     mem_req_o,
    output logic [MEM_ADDR_SIZE-1:0] mem_addr_o,
    input  logic                     mem_rvalid_i,
    input  logic [BYTE-1:0]          mem_rdata_i,
    output logic                     valid_o,
    input  logic                     ready_i,
    output logic [BYTE-1:0]          opcode_o,
    output logic [MEM_ADDR_SIZE-1:0] ea_o,
    output logic [BYTE-1:0]          operand_o,
    output logic                     page_cross_o
);

    localparam int unsigned AW = MEM_ADDR_SIZE;
    localparam int unsigned HW = MEM_ADDR_SIZE - BYTE;

    localparam logic [3:0] M_IMP  = 4'd0;
    localparam logic [3:0] M_ACC  = 4'd1;
    localparam logic [3:0] M_IMM  = 4'd2;
    localparam logic [3:0] M_ZP   = 4'd3;
    localparam logic [3:0] M_ZPX  = 4'd4;
    localparam logic [3:0] M_ZPY  = 4'd5;
    localparam logic [3:0] M_ABS  = 4'd6;
    localparam logic [3:0] M_ABSX = 4'd7;
    localparam logic [3:0] M_ABSY = 4'd8;
    localparam logic [3:0] M_IND  = 4'd9;
    localparam logic [3:0] M_INDX = 4'd10;
    localparam logic [3:0] M_INDY = 4'd11;
    localparam logic [3:0] M_REL  = 4'd12;

    typedef enum logic [2:0] {S_IDLE, S_PTR_LO, S_PTR_HI, S_LOAD, S_DONE} state_t;

    state_t          state_q, state_d;
    logic [BYTE-1:0] opcode_q, opcode_d;
    logic [3:0]      mode_q, mode_d;
    logic            load_q, load_d;
    logic [REG_SIZE-1:0] y_q, y_d;
    logic [BYTE-1:0] lo_q, lo_d;
    logic [AW-1:0]   ea_q, ea_d;
    logic [BYTE-1:0] operand_q, operand_d;
    logic            pcross_q, pcross_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic            req_q, req_d;
    logic            valid_q, valid_d;
    logic            ready_q, ready_d;

    // Address arithmetic on the incoming instruction (used at accept)
    logic [BYTE-1:0] op_lo, zp_x, zp_y;
    logic [AW-1:0]   op_full, abs_x, abs_y, rel_ea;
    assign op_lo   = operand_i[BYTE-1:0];
    assign op_full = AW'(operand_i);
    assign zp_x    = op_lo + BYTE'(X_i);
    assign zp_y    = op_lo + BYTE'(Y_i);
    assign abs_x   = op_full + AW'(X_i);
    assign abs_y   = op_full + AW'(Y_i);
    assign rel_ea  = pc_i + {{HW{op_lo[BYTE-1]}}, op_lo};

    // Pointer arithmetic during the pointer reads
    logic [AW-1:0] ind_hi_addr, hi_addr, ptr_ea, indy_ea, ind_ea;
`ifdef NMOS_JMP_IND_BUG_EN
    assign ind_hi_addr = {addr_q[AW-1:BYTE], addr_q[BYTE-1:0] + BYTE'(1)};
`else
    assign ind_hi_addr = addr_q + AW'(1);
`endif
    // INDX/INDY pointers never leave page 0
    assign hi_addr = (mode_q == M_IND) ? ind_hi_addr
                                       : {HW'(0), addr_q[BYTE-1:0] + BYTE'(1)};
    assign ptr_ea  = AW'({mem_rdata_i, lo_q});
    assign indy_ea = ptr_ea + AW'(y_q);
    assign ind_ea  = (mode_q == M_INDY) ? indy_ea : ptr_ea;

    // A response only counts while a request is actually pending
    logic rd_fire;
    assign rd_fire = req_q && mem_rvalid_i;

    // Next-state and next-output logic
    always_comb begin
        state_d   = state_q;
        opcode_d  = opcode_q;
        mode_d    = mode_q;
        load_d    = load_q;
        y_d       = y_q;
        lo_d      = lo_q;
        ea_d      = ea_q;
        operand_d = operand_q;
        pcross_d  = pcross_q;
        addr_d    = addr_q;

        case (state_q)
            S_IDLE: begin
                if (valid_i && ready_q) begin
                    opcode_d  = opcode_i;
                    mode_d    = addr_mode_i;
                    load_d    = load_i;
                    y_d       = Y_i;
                    lo_d      = '0;
                    ea_d      = '0;
                    operand_d = '0;
                    pcross_d  = 1'b0;
                    state_d   = S_DONE;
                    case (addr_mode_i)
                        M_IMP, M_ACC: ;
                        M_IMM:  operand_d = op_lo;
                        M_ZP:   ea_d = {HW'(0), op_lo};
                        M_ZPX:  ea_d = {HW'(0), zp_x};
                        M_ZPY:  ea_d = {HW'(0), zp_y};
                        M_ABS:  ea_d = op_full;
                        M_ABSX: begin
                            ea_d     = abs_x;
                            pcross_d = (abs_x[AW-1:BYTE] != op_full[AW-1:BYTE]);
                        end
                        M_ABSY: begin
                            ea_d     = abs_y;
                            pcross_d = (abs_y[AW-1:BYTE] != op_full[AW-1:BYTE]);
                        end
                        M_IND: begin
                            state_d = S_PTR_LO;
                            addr_d  = op_full;
                        end
                        M_INDX: begin
                            state_d = S_PTR_LO;
                            addr_d  = {HW'(0), zp_x};
                        end
                        M_INDY: begin
                            state_d = S_PTR_LO;
                            addr_d  = {HW'(0), op_lo};
                        end
                        M_REL: begin
                            ea_d     = rel_ea;
                            pcross_d = (rel_ea[AW-1:BYTE] != pc_i[AW-1:BYTE]);
                        end
                        default: ;
                    endcase
                    if (load_i && (addr_mode_i inside {M_ZP, M_ZPX, M_ZPY,
                                                       M_ABS, M_ABSX, M_ABSY})) begin
                        state_d = S_LOAD;
                        addr_d  = ea_d;
                    end
                end
            end
            S_PTR_LO: begin
                if (rd_fire) begin
                    lo_d    = mem_rdata_i;
                    addr_d  = hi_addr;
                    state_d = S_PTR_HI;
                end
            end
            S_PTR_HI: begin
                if (rd_fire) begin
                    ea_d = ind_ea;
                    if (mode_q == M_INDY) begin
                        pcross_d = (indy_ea[AW-1:BYTE] != HW'(mem_rdata_i));
                    end
                    if (load_q && (mode_q != M_IND)) begin
                        state_d = S_LOAD;
                        addr_d  = ind_ea;
                    end else begin
                        state_d = S_DONE;
                        addr_d  = '0;
                    end
                end
            end
            S_LOAD: begin
                if (rd_fire) begin
                    operand_d = mem_rdata_i;
                    addr_d    = '0;
                    state_d   = S_DONE;
                end
            end
            S_DONE: begin
                if (ready_i) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        req_d   = (state_d == S_PTR_LO) || (state_d == S_PTR_HI) || (state_d == S_LOAD);
        valid_d = (state_d == S_DONE);
        ready_d = (state_d == S_IDLE);
    end

    // State and output registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            opcode_q  <= BYTE'(8'hEA);
            mode_q    <= M_IMP;
            load_q    <= 1'b0;
            y_q       <= '0;
            lo_q      <= '0;
            ea_q      <= '0;
            operand_q <= '0;
            pcross_q  <= 1'b0;
            addr_q    <= '0;
            req_q     <= 1'b0;
            valid_q   <= 1'b0;
            ready_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            opcode_q  <= opcode_d;
            mode_q    <= mode_d;
            load_q    <= load_d;
            y_q       <= y_d;
            lo_q      <= lo_d;
            ea_q      <= ea_d;
            operand_q <= operand_d;
            pcross_q  <= pcross_d;
            addr_q    <= addr_d;
            req_q     <= req_d;
            valid_q   <= valid_d;
            ready_q   <= ready_d;
        end
    end

    assign ready_o      = ready_q;
    assign mem_req_o    = req_q;
    assign mem_addr_o   = addr_q;
    assign valid_o      = valid_q;
    assign opcode_o     = opcode_q;
    assign ea_o         = ea_q;
    assign operand_o    = operand_q;
    assign page_cross_o = pcross_q;

endmodule

// File: tb/tb_operand_fetch.sv
// Directed testbench for operand_fetch with a delay-configurable memory model.
module tb_operand_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_i, ready_o, load_i;
    logic [7:0]  opcode_i;
    logic [3:0]  addr_mode_i;
    logic [15:0] operand_i, pc_i;
    logic [7:0]  x_i, y_i;
    logic        mem_req_o, mem_rvalid_i;
    logic [15:0] mem_addr_o;
    logic [7:0]  mem_rdata_i;
    logic        valid_o, ready_i;
    logic [7:0]  opcode_o, operand_o;
    logic [15:0] ea_o;
    logic        page_cross_o;

    int n_checks = 0;
    int n_fail   = 0;

    // Memory model: answers each request after mem_delay cycles
    logic [7:0]  mem [0:65535];
    int          mem_delay = 0;
    logic        hold = 1'b0;
    logic        force_rv = 1'b0;
    int          wcnt = 0;
    logic [15:0] reads [$];
    logic        prev_pend = 1'b0;
    logic [15:0] prev_addr = '0;

    always #5 clk = ~clk;

    operand_fetch dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .valid_i      (valid_i),
        .ready_o      (ready_o),
        .opcode_i     (opcode_i),
        .addr_mode_i  (addr_mode_i),
        .load_i       (load_i),
        .operand_i    (operand_i),
        .pc_i         (pc_i),
        .X_i          (x_i),
        .Y_i          (y_i),
        .mem_req_o    (mem_req_o),
        .mem_addr_o   (mem_addr_o),
        .mem_rvalid_i (mem_rvalid_i),
        .mem_rdata_i  (mem_rdata_i),
        .valid_o      (valid_o),
        .ready_i      (ready_i),
        .opcode_o     (opcode_o),
        .ea_o         (ea_o),
        .operand_o    (operand_o),
        .page_cross_o (page_cross_o)
    );

    assign mem_rvalid_i = (mem_req_o && (wcnt >= mem_delay) && !hold) || force_rv;
    assign mem_rdata_i  = mem[mem_addr_o];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Wait counter, read log and request-stability monitor
    always @(posedge clk) begin
        if (rst || !mem_req_o || mem_rvalid_i) wcnt <= 0;
        else wcnt <= wcnt + 1;
        if (!rst && mem_req_o && mem_rvalid_i) reads.push_back(mem_addr_o);
        if (!rst && prev_pend) begin
            check("req_held", 32'(mem_req_o), 32'd1);
            check("addr_stable", 32'(mem_addr_o), 32'(prev_addr));
        end
        prev_pend <= !rst && mem_req_o && !mem_rvalid_i;
        prev_addr <= mem_addr_o;
    end

    task automatic send(input logic [3:0] mode, input logic [15:0] op, input logic ld,
                        input logic [7:0] x, input logic [7:0] y, input logic [15:0] pc,
                        input logic [7:0] opc);
        int n;
        @(negedge clk);
        reads.delete();
        addr_mode_i = mode; operand_i = op; load_i = ld;
        x_i = x; y_i = y; pc_i = pc; opcode_i = opc;
        valid_i = 1'b1;
        n = 0;
        while (!ready_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!ready_o) check("accept_timeout", 32'(ready_o), 32'd1);
        @(posedge clk);
        #1 valid_i = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!valid_o && lat < 60);
        check("valid_seen", 32'(valid_o), 32'd1);
    endtask

    task automatic handshake();
        ready_i = 1'b1;
        @(posedge clk);
        #1 ready_i = 1'b0;
        check("hs_valid_low", 32'(valid_o), 32'd0);
        check("hs_ready_high", 32'(ready_o), 32'd1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        int lat;
        logic [15:0] exp_hi_addr, exp_ea;

        mem[16'h0010] = 8'h5A;
        mem[16'h00FF] = 8'h00; mem[16'h0000] = 8'h30; mem[16'h3005] = 8'h77;
        mem[16'h3000] = 8'h99;
        mem[16'h0040] = 8'hF0; mem[16'h0041] = 8'h12;
        mem[16'h02FF] = 8'h34; mem[16'h0200] = 8'h12; mem[16'h0300] = 8'h56;
        mem[16'h0020] = 8'hCD;

        valid_i = 0; ready_i = 0; load_i = 0; opcode_i = 0; addr_mode_i = 0;
        operand_i = 0; pc_i = 0; x_i = 0; y_i = 0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_ready", 32'(ready_o), 32'd1);
        check("rst_valid", 32'(valid_o), 32'd0);
        check("rst_req", 32'(mem_req_o), 32'd0);
        check("rst_opcode", 32'(opcode_o), 32'hEA);
        check("rst_ea", 32'(ea_o), 32'd0);
        check("rst_operand", 32'(operand_o), 32'd0);
        check("rst_pcross", 32'(page_cross_o), 32'd0);
        check("rst_addr", 32'(mem_addr_o), 32'd0);
        rst = 1'b0;

        // ZPX load, zero-page wrap, zero-wait memory
        send(4'd4, 16'h00F0, 1'b1, 8'h20, 8'h00, 16'h0000, 8'hB5);
        wait_done(lat);
        check("zpx_lat", 32'(lat), 32'd2);
        check("zpx_nreads", 32'(reads.size()), 32'd1);
        if (reads.size() > 0) check("zpx_raddr", 32'(reads[0]), 32'h0010);
        check("zpx_ea", 32'(ea_o), 32'h0010);
        check("zpx_operand", 32'(operand_o), 32'h5A);
        check("zpx_pcross", 32'(page_cross_o), 32'd0);
        check("zpx_opcode", 32'(opcode_o), 32'hB5);
        handshake();

        // ABSY store with page cross; outputs held while execute stalls
        send(4'd8, 16'h12F0, 1'b0, 8'h00, 8'h20, 16'h0000, 8'h99);
        wait_done(lat);
        check("absy_lat", 32'(lat), 32'd1);
        check("absy_nreads", 32'(reads.size()), 32'd0);
        check("absy_ea", 32'(ea_o), 32'h1310);
        check("absy_pcross", 32'(page_cross_o), 32'd1);
        @(negedge clk);
        check("absy_valid_held", 32'(valid_o), 32'd1);
        check("absy_ea_held", 32'(ea_o), 32'h1310);
        handshake();

        // INDY with pointer at 0xFF (page-0 wrap) and 3-cycle memory latency
        mem_delay = 3;
        send(4'd11, 16'h00FF, 1'b1, 8'h00, 8'h05, 16'h0000, 8'hB1);
        wait_done(lat);
        check("indy_lat", 32'(lat), 32'd13);
        check("indy_nreads", 32'(reads.size()), 32'd3);
        if (reads.size() == 3) begin
            check("indy_raddr0", 32'(reads[0]), 32'h00FF);
            check("indy_raddr1", 32'(reads[1]), 32'h0000);
            check("indy_raddr2", 32'(reads[2]), 32'h3005);
        end
        check("indy_ea", 32'(ea_o), 32'h3005);
        check("indy_operand", 32'(operand_o), 32'h77);
        check("indy_pcross", 32'(page_cross_o), 32'd0);
        handshake();
        mem_delay = 0;

        // INDY store crossing a page after adding Y
        send(4'd11, 16'h0040, 1'b0, 8'h00, 8'h20, 16'h0000, 8'h91);
        wait_done(lat);
        check("indy2_lat", 32'(lat), 32'd3);
        check("indy2_ea", 32'(ea_o), 32'h1310);
        check("indy2_pcross", 32'(page_cross_o), 32'd1);
        handshake();

        // INDX with pointer wrapping from 0xFF to 0x00
        send(4'd10, 16'h00FE, 1'b1, 8'h01, 8'h00, 16'h0000, 8'hA1);
        wait_done(lat);
        check("indx_lat", 32'(lat), 32'd4);
        check("indx_nreads", 32'(reads.size()), 32'd3);
        if (reads.size() == 3) begin
            check("indx_raddr0", 32'(reads[0]), 32'h00FF);
            check("indx_raddr1", 32'(reads[1]), 32'h0000);
        end
        check("indx_ea", 32'(ea_o), 32'h3000);
        check("indx_operand", 32'(operand_o), 32'h99);
        handshake();

        // IND across a page boundary; build option selects the high-byte address
`ifdef NMOS_JMP_IND_BUG_EN
        exp_hi_addr = 16'h0200; exp_ea = 16'h1234;
`else
        exp_hi_addr = 16'h0300; exp_ea = 16'h5634;
`endif
        send(4'd9, 16'h02FF, 1'b1, 8'h00, 8'h00, 16'h0000, 8'h6C);
        wait_done(lat);
        check("ind_lat", 32'(lat), 32'd3);
        check("ind_nreads", 32'(reads.size()), 32'd2);
        if (reads.size() == 2) begin
            check("ind_raddr0", 32'(reads[0]), 32'h02FF);
            check("ind_raddr1", 32'(reads[1]), 32'(exp_hi_addr));
        end
        check("ind_ea", 32'(ea_o), 32'(exp_ea));
        handshake();

        // REL forward across a page, then backward within the page
        send(4'd12, 16'h0020, 1'b0, 8'h00, 8'h00, 16'h10F0, 8'hD0);
        wait_done(lat);
        check("rel_fwd_lat", 32'(lat), 32'd1);
        check("rel_fwd_ea", 32'(ea_o), 32'h1110);
        check("rel_fwd_pcross", 32'(page_cross_o), 32'd1);
        handshake();
        send(4'd12, 16'h0080, 1'b0, 8'h00, 8'h00, 16'h10F0, 8'hD0);
        wait_done(lat);
        check("rel_bwd_ea", 32'(ea_o), 32'h1070);
        check("rel_bwd_pcross", 32'(page_cross_o), 32'd0);
        handshake();

        // IMM: operand is the first byte, no EA
        send(4'd2, 16'h55AB, 1'b1, 8'h00, 8'h00, 16'h0000, 8'hA9);
        wait_done(lat);
        check("imm_operand", 32'(operand_o), 32'hAB);
        check("imm_ea", 32'(ea_o), 32'd0);
        check("imm_nreads", 32'(reads.size()), 32'd0);
        handshake();

        // Reserved mode 14 behaves as IMP
        send(4'd14, 16'h1234, 1'b1, 8'h00, 8'h00, 16'h0000, 8'hEA);
        wait_done(lat);
        check("imp_ea", 32'(ea_o), 32'd0);
        check("imp_operand", 32'(operand_o), 32'd0);
        handshake();

        // Reset while waiting for the pointer high byte; late rvalid ignored
        send(4'd11, 16'h0010, 1'b1, 8'h00, 8'h00, 16'h0000, 8'hB1);
        @(posedge clk);
        #1 hold = 1'b1;
        @(negedge clk);
        check("rstmid_req", 32'(mem_req_o), 32'd1);
        check("rstmid_addr", 32'(mem_addr_o), 32'h0011);
        rst = 1'b1;
        #1;
        check("rstmid_req_drop", 32'(mem_req_o), 32'd0);
        check("rstmid_valid", 32'(valid_o), 32'd0);
        check("rstmid_ready", 32'(ready_o), 32'd1);
        check("rstmid_opcode", 32'(opcode_o), 32'hEA);
        @(negedge clk);
        rst = 1'b0;
        hold = 1'b0;
        force_rv = 1'b1;
        @(negedge clk);
        force_rv = 1'b0;
        @(negedge clk);
        check("late_rv_valid", 32'(valid_o), 32'd0);
        check("late_rv_ready", 32'(ready_o), 32'd1);
        check("late_rv_req", 32'(mem_req_o), 32'd0);
        check("late_rv_opcode", 32'(opcode_o), 32'hEA);
        check("late_rv_ea", 32'(ea_o), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
